// File: rtl/lstm_cell_sequencer.sv
// lstm_cell_sequencer: steps a combinational LSTM cell datapath through a
// sequence of timesteps. Each step takes one gate vector over a valid/ready
// handshake and holds it on the datapath for SETTLE_CYCLES cycles. It then
// captures the new cell state and hidden output, and feeds the cell state
// back as the next step's previous state.
// Optional build macro: LSTM_SEQ_KEEP_STATE_EN. When defined, start keeps the
// last captured cell state and hidden output instead of clearing them.
module lstm_cell_sequencer #(
    parameter int unsigned VEC           = 100,
    parameter int unsigned GATES         = 400,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned LEN_W         = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_start,
    input  logic [LEN_W-1:0]            i_seq_len,
    output logic                        o_busy,
    input  logic                        i_in_valid,
    output logic                        o_in_ready,
    input  logic [GATES-1:0][31:0]      i_in_gates,
    output logic [GATES-1:0][31:0]      o_dp_gates,
    output logic [VEC-1:0][31:0]        o_dp_c_prev,
    input  logic [VEC-1:0][31:0]        i_dp_c_next,
    input  logic [VEC-1:0][31:0]        i_dp_h_t,
    output logic                        o_out_valid,
    input  logic                        i_out_ready,
    output logic [VEC-1:0][31:0]        o_out_h,
    output logic                        o_out_last,
    output logic [LEN_W-1:0]            o_step_idx,
    output logic                        o_done
);

    localparam int unsigned CNT_W = 4;

`ifdef LSTM_SEQ_KEEP_STATE_EN
    localparam bit CLEAR_ON_START = 1'b0;
`else
    localparam bit CLEAR_ON_START = 1'b1;
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_IN = 3'd1,
        S_SETTLE  = 3'd2,
        S_OUTPUT  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_start_run;
    logic                   w_hs_in;
    logic                   w_capture;
    logic                   w_hs_out;
    logic                   w_is_last;

    logic [CNT_W-1:0]       r_cnt;
    logic [LEN_W-1:0]       r_len;
    logic [LEN_W-1:0]       r_step_idx;
    logic [GATES-1:0][31:0] r_dp_gates;
    logic [VEC-1:0][31:0]   r_c;
    logic [VEC-1:0][31:0]   r_out_h;
    logic                   r_busy;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic                   r_out_last;
    logic                   r_done;

    assign w_is_last = (r_step_idx == (r_len - LEN_W'(1)));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake/capture strobes
    always_comb begin
        w_state_nxt = r_state;
        w_start_run = 1'b0;
        w_hs_in     = 1'b0;
        w_capture   = 1'b0;
        w_hs_out    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_seq_len != '0) begin
                        w_start_run = 1'b1;
                        w_state_nxt = S_WAIT_IN;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_WAIT_IN: begin
                if (i_in_valid) begin
                    w_hs_in     = 1'b1;
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (i_out_ready) begin
                    w_hs_out    = 1'b1;
                    w_state_nxt = w_is_last ? S_DONE : S_WAIT_IN;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Control outputs registered from next state so they depend on state only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_busy      <= (w_state_nxt != S_IDLE);
            r_in_ready  <= (w_state_nxt == S_WAIT_IN);
            r_out_valid <= (w_state_nxt == S_OUTPUT);
            r_out_last  <= (w_state_nxt == S_OUTPUT) && w_is_last;
            r_done      <= (w_state_nxt == S_DONE);
        end
    end

    // Sequence length, step index and settle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len      <= '0;
            r_step_idx <= '0;
            r_cnt      <= '0;
        end else begin
            if (w_start_run) begin
                r_len      <= i_seq_len;
                r_step_idx <= '0;
            end
            if (w_hs_out && !w_is_last) begin
                r_step_idx <= r_step_idx + LEN_W'(1);
            end
            if (w_hs_in) begin
                r_cnt <= CNT_W'(SETTLE_CYCLES - 1);
            end else if ((r_state == S_SETTLE) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // Datapath operand and result registers; held constant across SETTLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dp_gates <= '0;
            r_c        <= '0;
            r_out_h    <= '0;
        end else begin
            if (w_start_run && CLEAR_ON_START) begin
                r_c     <= '0;
                r_out_h <= '0;
            end
            if (w_hs_in) begin
                r_dp_gates <= i_in_gates;
            end
            if (w_capture) begin
                r_c     <= i_dp_c_next;
                r_out_h <= i_dp_h_t;
            end
        end
    end

    assign o_busy      = r_busy;
    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_last  = r_out_last;
    assign o_done      = r_done;
    assign o_step_idx  = r_step_idx;
    assign o_dp_gates  = r_dp_gates;
    assign o_dp_c_prev = r_c;
    assign o_out_h     = r_out_h;

endmodule

// File: tb/tb_lstm_cell_sequencer.sv
// Self-checking bench for lstm_cell_sequencer with a behavioural datapath:
// c_next = c_prev + gates[0..VEC-1], h = gates[VEC..2*VEC-1].
module tb_lstm_cell_sequencer;

    localparam int unsigned VEC    = 100;
    localparam int unsigned GATES  = 400;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned LEN_W  = 8;

    logic                   clk;
    logic                   rst_n;
    logic                   start;
    logic [LEN_W-1:0]       seq_len;
    logic                   busy;
    logic                   in_valid;
    logic                   in_ready;
    logic [GATES-1:0][31:0] in_gates;
    logic [GATES-1:0][31:0] dp_gates;
    logic [VEC-1:0][31:0]   dp_c_prev;
    logic [VEC-1:0][31:0]   dp_c_next;
    logic [VEC-1:0][31:0]   dp_h_t;
    logic                   out_valid;
    logic                   out_ready;
    logic [VEC-1:0][31:0]   out_h;
    logic                   out_last;
    logic [LEN_W-1:0]       step_idx;
    logic                   done;

    typedef struct {
        logic [31:0]      h0;
        logic             last;
        logic [LEN_W-1:0] idx;
        logic [31:0]      c0;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_c0 = 0;
    int          exp_idx = 0;

    lstm_cell_sequencer #(
        .VEC(VEC), .GATES(GATES), .SETTLE_CYCLES(SETTLE), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_start(start), .i_seq_len(seq_len), .o_busy(busy),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_gates(in_gates),
        .o_dp_gates(dp_gates), .o_dp_c_prev(dp_c_prev),
        .i_dp_c_next(dp_c_next), .i_dp_h_t(dp_h_t),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_h(out_h),
        .o_out_last(out_last), .o_step_idx(step_idx), .o_done(done)
    );

    for (genvar gi = 0; gi < VEC; gi++) begin : g_dp
        assign dp_c_next[gi] = dp_c_prev[gi] + dp_gates[gi];
        assign dp_h_t[gi]    = dp_gates[VEC + gi];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic begin_seq(input int len);
        start   = 1'b1;
        seq_len = LEN_W'(len);
        tick();
        start   = 1'b0;
        seq_len = '0;
`ifndef LSTM_SEQ_KEEP_STATE_EN
        if (len != 0) exp_c0 = 0;
`endif
        exp_idx = 0;
    endtask

    // One timestep: mode 0 -> gates[j]=j, mode 1 -> all gates 5
    task automatic do_step(input int mode, input bit last, input int stall);
        int   n;
        exp_t e;
        logic [31:0] hold;
        n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        chk("in_ready", in_ready, 1);
        chk("c_prev_before", dp_c_prev[0], exp_c0);
        chk("step_idx_wait", step_idx, exp_idx);
        for (int j = 0; j < GATES; j++) in_gates[j] = (mode == 0) ? 32'(j) : 32'd5;
        in_valid = 1'b1;
        e.h0   = (mode == 0) ? 32'd100 : 32'd5;
        e.last = last;
        e.idx  = LEN_W'(exp_idx);
        e.c0   = exp_c0 + ((mode == 0) ? 32'd0 : 32'd5);
        sb.push_back(e);
        exp_c0 = e.c0;
        tick();
        in_valid = 1'b0;
        for (int j = 0; j < GATES; j++) in_gates[j] = 32'hDEAD_BEEF;
        chk("dp_gates_held", dp_gates[GATES-1], (mode == 0) ? 64'd399 : 64'd5);
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        chk("out_latency", 64'(n), 64'(SETTLE));
        for (int s = 0; s < stall; s++) begin
            hold = out_h[0];
            if (s == 0) begin start = 1'b1; seq_len = '0; end
            tick();
            start = 1'b0;
            chk("stall_h_stable", out_h[0], hold);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
        end
        if (sb.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            chk("out_h0", out_h[0], e.h0);
            chk("out_last", out_last, e.last);
            chk("step_idx_out", step_idx, e.idx);
            chk("c_captured", dp_c_prev[0], e.c0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        if (!last) exp_idx++;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; seq_len = '0; in_valid = 1'b0;
        out_ready = 1'b0; in_gates = '0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_dp_gates", 64'(|dp_gates), 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Single step
        begin_seq(1);
        chk("busy_run", busy, 1);
        do_step(0, 1'b1, 0);
        chk("done_pulse", done, 1);
        tick();
        chk("done_clear", done, 0);
        chk("idle_busy", busy, 0);

        // Recurrence with backpressure and an ignored start pulse
        begin_seq(3);
        do_step(1, 1'b0, 0);
        do_step(1, 1'b0, 10);
        do_step(1, 1'b1, 0);
        chk("rec_done", done, 1);
        tick();

        // Zero length
        begin_seq(0);
        chk("zl_done", done, 1);
        chk("zl_in_ready", in_ready, 0);
        chk("zl_out_valid", out_valid, 0);
        tick();
        chk("zl_done_clear", done, 0);
        chk("zl_busy", busy, 0);

        // Reset in the middle of SETTLE
        begin_seq(1);
        for (int j = 0; j < GATES; j++) in_gates[j] = 32'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_dp_gates", 64'(|dp_gates), 0);
        chk("mrst_c_prev", 64'(|dp_c_prev), 0);
        chk("mrst_out_h", 64'(|out_h), 0);
        chk("mrst_step_idx", step_idx, 0);
        sb.delete();
        exp_c0 = 0;
        #3 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_busy", busy, 0);
            chk("post_rst_done", done, 0);
        end

        // Two back-to-back single-step sequences from c=0
        begin_seq(1);
        do_step(1, 1'b1, 0);
        tick();
        begin_seq(1);
        do_step(1, 1'b1, 0);
`ifdef LSTM_SEQ_KEEP_STATE_EN
        chk("macro_final_c", dp_c_prev[0], 10);
`else
        chk("macro_final_c", dp_c_prev[0], 5);
`endif
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lstm_cell_sequencer.md
# lstm_cell_sequencer

Multi-cycle sequencer for the combinational LSTM cell datapath (100-element state, 400-element gate pre-activation vector). It runs a sequence of timesteps: accepts one gate vector per step over a valid/ready handshake, holds it stable on the datapath for a programmable settle window, captures the new cell state and hidden output, and recirculates the cell state as the next step's previous state. The sequencer sits between the gate-matmul stage upstream and the hidden-state consumer downstream.

## Interface
- `VEC`, 100, cell/hidden vector length.
- `GATES`, 400, gate pre-activation vector length (4*VEC).
- `SETTLE_CYCLES`, 2, cycles the datapath inputs are held before capture; legal range 1..15.
- `LEN_W`, 8, width of the sequence length and step index.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a sequence; sampled only in IDLE.
- `seq_len`  in  LEN_W  timesteps in the sequence, sampled with `start`.
- `busy`  out  1  high in every state except IDLE.
- `in_valid` / `in_ready`  in / out  1  gate vector handshake.
- `in_gates`  in  32 signed x GATES  gate pre-activations for one step.
- `dp_gates`  out  32 signed x GATES  registered gate vector driven to the datapath.
- `dp_c_prev`  out  32 signed x VEC  registered cell state driven to the datapath.
- `dp_c_next`, `dp_h_t`  in  32 signed x VEC  datapath results.
- `out_valid` / `out_ready`  out / in  1  hidden-state handshake.
- `out_h`  out  32 signed x VEC  captured hidden state.
- `out_last`  out  1  high with `out_valid` on the final step.
- `step_idx`  out  LEN_W  index of the current step, 0-based.
- `done`  out  1  one-cycle pulse at sequence end.

## Operation
- States: IDLE, WAIT_IN, SETTLE, OUTPUT, DONE.
- IDLE: `start`=1, `seq_len`!=0 -> latch length, `step_idx`<=0, clear cell state and `out_h` to 0, go WAIT_IN. `start`=1, `seq_len`=0 -> go DONE, with no data transfer.
- WAIT_IN: `in_ready`=1. On `in_valid` -> `dp_gates`<=`in_gates`, settle counter<=SETTLE_CYCLES-1, go SETTLE.
- SETTLE: counter decrements each cycle. In the cycle where the counter is 0, cell state<=`dp_c_next` and `out_h`<=`dp_h_t`; go OUTPUT.
- OUTPUT: `out_valid`=1; `out_last`=(`step_idx`==len-1). On `out_ready`: if last, go DONE; otherwise `step_idx`++ and go WAIT_IN.
- DONE: `done`=1 for one cycle -> IDLE.
- `start` is ignored while `busy`. `out_h` and `out_last` remain stable while `out_valid` is high and unacknowledged. Data moves only in the handshake cycle.
- No arithmetic on data paths. All values pass through unchanged as 32-bit signed.
- Asynchronous reset: state IDLE. All outputs and registers are 0, including `dp_*`, `out_h`, `step_idx`, `done`, and the handshakes. A reset mid-sequence aborts the sequence and produces no `done`.

## Timing
- Input handshake at edge k -> SETTLE spans cycles k+1..k+SETTLE_CYCLES. Capture occurs at the edge ending cycle k+SETTLE_CYCLES. `out_valid` is high from cycle k+SETTLE_CYCLES+1.
- Minimum step period is SETTLE_CYCLES+2 cycles (WAIT_IN, SETTLE, OUTPUT), given zero stall.
- `done` is asserted in the cycle after the final output handshake.
- `in_ready`, `out_valid`, `out_last`, `busy`, and `done` are decoded from state only, with no combinational path from inputs.
- `dp_gates` and `dp_c_prev` change only at the input-handshake edge and the capture edge respectively. The datapath sees stable inputs for the full SETTLE window (multicycle path).

## Configuration
- `LSTM_SEQ_KEEP_STATE_EN` defined: `start` does not clear the cell state or `out_h`. A new sequence continues from the last captured cell state (stateful inference across calls).
- Undefined: `start` zeroes the cell state and `out_h`, so every sequence begins from c=0.

## Test plan
- Reset: assert `rst_n`=0 mid-SETTLE -> all outputs 0 and state IDLE immediately; after release, `busy`=0 and `done` stays 0.
- Single step: SETTLE_CYCLES=2, `seq_len`=1, datapath model c_next=c_prev+gates[0..99], h=gates[100..199]. Input with gates[j]=j -> `out_h`[0]=100, `out_last`=1, `out_valid` 3 cycles after the input handshake, and `done` one cycle after `out_ready`.
- Recurrence: `seq_len`=3, every gate vector 5 -> `dp_c_prev`[0] is 0, then 5, then 10, across the three steps; `step_idx` is 0, 1, 2.
- Backpressure: hold `out_ready`=0 for 10 cycles -> `out_h` is stable, `in_ready`=0 throughout, and no step is lost.
- Zero length: `start` with `seq_len`=0 -> `done` pulse in the next cycle, with `in_ready` and `out_valid` never asserted. A `start` pulse while `busy` has no effect.
- Macro: run two back-to-back sequences of 1 step with gates 5. Final c is 10 with `LSTM_SEQ_KEEP_STATE_EN` defined and 5 without it.
